pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters: CNT_W, default 16, width of the saturating performance counters; LOAD_SRC, default 2'b01, ru_data_src code that marks a data-memory load.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- de_rs1, de_rs2  in  5 each  source registers of the instruction in decode
- de_uses_rs1, de_uses_rs2  in  1 each  decode instruction actually reads that source
- ex_rs1, ex_rs2  in  5 each  source registers held in the DE/EX register
- ex_rd  in  5  destination register in execute
- ex_reg_write  in  1  execute instruction writes the register file
- ex_ru_data_src  in  2  execute instruction's register-file data source
- ex_valid  in  1  execute slot holds a real instruction
- ex_branch_taken  in  1  execute resolved a taken branch or jump
- mem_rd, wb_rd  in  5 each  destination registers in memory and writeback
- mem_reg_write, wb_reg_write  in  1 each  register write enables in memory and writeback
- pc_stall  out  1  hold the PC
- if_de_stall  out  1  hold the IF/DE register
- if_de_flush  out  1  load a bubble into IF/DE
- de_ex_flush  out  1  load a bubble into DE/EX
- fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source: 00 register file, 01 memory stage, 10 writeback
- state  out  2  FSM state: 00 RUN, 01 STALL, 10 REDIRECT
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Function
REQ-003 Load-use hazard (lu) SHALL be true when all of the following hold:
- ex_valid is 1, ex_reg_write is 1, ex_ru_data_src is LOAD_SRC, and ex_rd is not 0
- either de_uses_rs1 is 1 and ex_rd equals de_rs1, or de_uses_rs2 is 1 and ex_rd equals de_rs2
REQ-004 Branch redirect (br) SHALL be true when ex_valid and ex_branch_taken are both 1.
REQ-005 When br is true, if_de_flush and de_ex_flush SHALL both be 1 and pc_stall and if_de_stall SHALL both be 0, in the same cycle (combinational).
REQ-006 When lu is true, br is false, and state is not REDIRECT, pc_stall, if_de_stall and de_ex_flush SHALL all be 1 and if_de_flush SHALL be 0, in the same cycle.
REQ-007 br SHALL have priority over lu.
REQ-008 When state is REDIRECT, lu SHALL be ignored because the decode slot holds a bubble.
REQ-009 When neither REQ-005 nor REQ-006 applies, all four stall/flush outputs SHALL be 0.
REQ-010 fwd_a_sel SHALL be:
- 01 if mem_reg_write is 1, mem_rd is not 0, and mem_rd equals ex_rs1
- otherwise 10 if wb_reg_write is 1, wb_rd is not 0, and wb_rd equals ex_rs1
- otherwise 00
REQ-011 fwd_b_sel SHALL follow REQ-010 using ex_rs2.
REQ-012 The memory stage SHALL win when both the memory and writeback stages match.
REQ-013 Forwarding SHALL be purely combinational and independent of the FSM.
REQ-014 FSM state changes SHALL happen on the rising edge of clk, as follows:
- RUN: br goes to REDIRECT; else lu goes to STALL; else stays in RUN
- STALL: br goes to REDIRECT; else lu stays in STALL; else goes to RUN
- REDIRECT: br stays in REDIRECT; else goes to RUN
REQ-015 Code 2'b11 SHALL be unreachable; if it is ever entered, the FSM SHALL go to RUN on the next edge and drive all stall/flush outputs to 0 while in it.
REQ-016 stall_cnt SHALL increment by 1 on each edge where pc_stall was 1.
REQ-017 flush_cnt SHALL increment by 1 on each edge where if_de_flush was 1.
REQ-018 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 A back-to-back load-use SHALL hold the stall and count one cycle per stalled edge.
REQ-020 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-021 While rst is 1:
- state SHALL be RUN and stall_cnt and flush_cnt SHALL be 0, asynchronously
- pc_stall, if_de_stall, if_de_flush and de_ex_flush SHALL be 0 regardless of the other inputs
REQ-022 Forwarding selects SHALL remain combinational during reset.
REQ-023 Reset asserted mid-STALL or mid-REDIRECT SHALL abandon that state immediately.
REQ-024 On the first edge after rst falls, the FSM SHALL evaluate from RUN.

Verification
REQ-025 Load-use: ex_rd=5, ex_ru_data_src=01, ex_reg_write=1, de_rs1=5, de_uses_rs1=1 -> pc_stall=if_de_stall=de_ex_flush=1 that cycle; state=STALL after the edge; stall_cnt=1.
REQ-026 Branch beats load-use: lu true and ex_branch_taken=1 in the same cycle -> if_de_flush=de_ex_flush=1, pc_stall=0; state=REDIRECT; flush_cnt=1, stall_cnt=0.
REQ-027 Forwarding priority: mem_rd=wb_rd=ex_rs1=7, both write enables 1 -> fwd_a_sel=01; set mem_rd=0 -> fwd_a_sel=10; set ex_rs1=0 -> fwd_a_sel=00.
REQ-028 x0 filter: load with ex_rd=0 and de_rs1=0 -> no stall; the stall counter does not change.
REQ-029 Saturation: CNT_W=4 and 20 consecutive stall cycles -> stall_cnt holds 15.
REQ-030 Reset mid-operation: assert rst while state=STALL -> state=00, all stall/flush outputs 0 and counters 0 immediately, before any clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall and branch-redirect control, EX operand
// forwarding selects, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [1:0]  LOAD_SRC = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_uses_rs1,
  input  logic             de_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_ru_data_src,
  input  logic             ex_valid,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  output logic             pc_stall,
  output logic             if_de_stall,
  output logic             if_de_flush,
  output logic             de_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, REDIRECT = 2'b10, ILLEGAL = 2'b11} state_e;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu, br, hold, kill, live;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) ? 2'b01 :
           (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)    ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    lu = ex_valid && ex_reg_write && ex_ru_data_src == LOAD_SRC && ex_rd != 5'd0 &&
         ((de_uses_rs1 && ex_rd == de_rs1) || (de_uses_rs2 && ex_rd == de_rs2));
    br = ex_valid && ex_branch_taken;
    // The illegal code and reset both force every control output low.
    live = !rst && state_q != ILLEGAL;
    kill = live && br;
    hold = live && !br && lu && state_q != REDIRECT;
    pc_stall    = hold;
    if_de_stall = hold;
    if_de_flush = kill;
    de_ex_flush = kill || hold;
    fwd_a_sel   = fwd(ex_rs1);
    fwd_b_sel   = fwd(ex_rs2);
    state       = state_q;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
    state_d = state_q == ILLEGAL ? RUN :
              br ? REDIRECT :
              (lu && state_q != REDIRECT) ? STALL : RUN;
    stall_cnt_d = (pc_stall && !(&stall_cnt_q)) ? stall_cnt_q + ONE : stall_cnt_q;
    flush_cnt_d = (if_de_flush && !(&flush_cnt_q)) ? flush_cnt_q + ONE : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a rule-level model of the hazard controller.
module tb_pipeline_hazard_ctrl;
  localparam int W = 4;
  localparam int MAXC = 15;
  logic clk, rst;
  logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic de_uses_rs1, de_uses_rs2, ex_reg_write, ex_valid, ex_branch_taken;
  logic mem_reg_write, wb_reg_write;
  logic [1:0] ex_ru_data_src;
  logic pc_stall, if_de_stall, if_de_flush, de_ex_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, state;
  logic [W-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  int m_state = 0, m_sc = 0, m_fc = 0;

  pipeline_hazard_ctrl #(.CNT_W(W), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_ru_data_src(ex_ru_data_src), .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_stall(pc_stall), .if_de_stall(if_de_stall), .if_de_flush(if_de_flush),
    .de_ex_flush(de_ex_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
    end
  endtask

  // Model: hazard rules and forwarding priority as plain predicates.
  function automatic bit m_lu();
    bit hit1 = de_uses_rs1 && de_rs1 == ex_rd;
    bit hit2 = de_uses_rs2 && de_rs2 == ex_rd;
    return ex_valid && ex_reg_write && ex_ru_data_src == 2'b01 && ex_rd != 0 && (hit1 || hit2);
  endfunction
  function automatic bit m_br();
    return ex_valid && ex_branch_taken;
  endfunction
  function automatic bit m_stall();
    return !rst && !m_br() && m_lu() && m_state != 2;
  endfunction
  function automatic bit m_flush();
    return !rst && m_br();
  endfunction
  function automatic int m_next();
    if (m_br()) return 2;
    if (m_lu() && m_state != 2) return 1;
    return 0;
  endfunction
  function automatic int m_fwd(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (mem_reg_write && mem_rd == rs) return 1;
    if (wb_reg_write && wb_rd == rs) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_state <= 0;
      m_sc <= 0;
      m_fc <= 0;
    end else begin
      m_state <= m_next();
      m_sc <= (m_stall() && m_sc < MAXC) ? m_sc + 1 : m_sc;
      m_fc <= (m_flush() && m_fc < MAXC) ? m_fc + 1 : m_fc;
    end

  always @(negedge clk) begin
    chk("pc_stall", pc_stall, m_stall());
    chk("if_de_stall", if_de_stall, m_stall());
    chk("if_de_flush", if_de_flush, m_flush());
    chk("de_ex_flush", de_ex_flush, m_stall() || m_flush());
    chk("fwd_a_sel", fwd_a_sel, m_fwd(ex_rs1));
    chk("fwd_b_sel", fwd_b_sel, m_fwd(ex_rs2));
    chk("state", state, m_state);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {de_uses_rs1, de_uses_rs2, ex_reg_write, ex_valid, ex_branch_taken} = '0;
    {mem_reg_write, wb_reg_write} = '0;
    ex_ru_data_src = 2'b00;
  endtask
  task automatic set_lu();
    ex_valid = 1; ex_reg_write = 1; ex_ru_data_src = 2'b01; ex_rd = 5; de_rs1 = 5; de_uses_rs1 = 1;
  endtask
  task automatic rst_pulse();
    rst = 1;
    #1 rst = 0;
  endtask
  task automatic ctl(input string n, input logic [3:0] exp);
    chk({n, "_ctl"}, {pc_stall, if_de_stall, if_de_flush, de_ex_flush}, exp);
  endtask

  initial begin
    rst = 1;
    clear();
    ex_valid = 1; ex_branch_taken = 1;
    mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3;
    #3;
    chk("reset_state", state, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    ctl("reset", 4'b0000);
    chk("reset_fwd", fwd_a_sel, 1);
    tick();
    rst = 0;
    clear();
    set_lu();
    #1 ctl("loaduse", 4'b1101);
    tick();
    chk("loaduse_state", state, 1);
    chk("loaduse_cnt", stall_cnt, 1);
    clear();
    rst_pulse();
    set_lu();
    ex_branch_taken = 1;
    #1 ctl("br_wins", 4'b0011);
    tick();
    chk("br_state", state, 2);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);
    clear();
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_reg_write = 1; wb_reg_write = 1;
    #1 chk("fwd_mem", fwd_a_sel, 1);
    mem_rd = 0;
    #1 chk("fwd_wb", fwd_a_sel, 2);
    ex_rs1 = 0;
    #1 chk("fwd_x0", fwd_a_sel, 0);
    tick();
    clear();
    rst_pulse();
    ex_valid = 1; ex_reg_write = 1; ex_ru_data_src = 2'b01; de_uses_rs1 = 1;
    #1 ctl("x0_load", 4'b0000);
    tick();
    chk("x0_cnt", stall_cnt, 0);
    chk("x0_state", state, 0);
    rst_pulse();
    set_lu();
    repeat (20) tick();
    chk("sat_cnt", stall_cnt, MAXC);
    chk("sat_state", state, 1);
    rst = 1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_stall_cnt", stall_cnt, 0);
    chk("midrst_flush_cnt", flush_cnt, 0);
    ctl("midrst", 4'b0000);
    tick();
    rst = 0;
    clear();
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 49) == 0);
      de_rs1 = 5'($urandom_range(0, 3));
      de_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3));
      ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      de_uses_rs1 = 1'($urandom_range(0, 1));
      de_uses_rs2 = 1'($urandom_range(0, 1));
      ex_reg_write = ($urandom_range(0, 3) != 0);
      ex_ru_data_src = $urandom_range(0, 1) ? 2'b01 : 2'($urandom_range(0, 3));
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write = 1'($urandom_range(0, 1));
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
